// File: rtl/z80_bus_tracer.sv
// Z80 bus-cycle tracer.
// Watches the Z80 control/address/data pins, groups contiguous MREQ/IORQ
// activity into bus-cycle windows, classifies each completed window and
// queues a {type, address, data, timestamp} record in a show-ahead FIFO.
// Dropped records (FIFO full) are counted and flagged.

module z80_bus_tracer #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    m1_n,
    input  logic                    mreq_n,
    input  logic                    iorq_n,
    input  logic                    rd_n,
    input  logic                    wr_n,
    input  logic                    rfsh_n,
    input  logic [15:0]             addr,
    input  logic [7:0]              data,
    input  logic                    enable,
    input  logic [6:0]              filter_mask,
    input  logic                    pop,
    input  logic                    clear,
    output logic                    rec_valid,
    output logic [2:0]              rec_type,
    output logic [ADDR_W-1:0]       rec_addr,
    output logic [7:0]              rec_data,
    output logic [TS_W-1:0]         rec_ts,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    full,
    output logic                    overflow,
    output logic [7:0]              drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    localparam logic [2:0] T_FETCH   = 3'd0;
    localparam logic [2:0] T_MEM_RD  = 3'd1;
    localparam logic [2:0] T_MEM_WR  = 3'd2;
    localparam logic [2:0] T_IO_RD   = 3'd3;
    localparam logic [2:0] T_IO_WR   = 3'd4;
    localparam logic [2:0] T_INT_ACK = 3'd5;
    localparam logic [2:0] T_REFRESH = 3'd6;
    localparam logic [2:0] T_UNKNOWN = 3'd7;

    // Control activity observed during a window (all active-high here).
    typedef struct packed {
        logic m1;
        logic rd;
        logic wr;
        logic rfsh;
        logic io;
        logic mem;
    } seen_t;

    typedef struct packed {
        logic [2:0]        typ;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
        logic [TS_W-1:0]   ts;
    } rec_t;

    // ------------------------------------------------------------------
    // Input stage
    // ------------------------------------------------------------------
    logic              s_m1_n_q, s_mreq_n_q, s_iorq_n_q;
    logic              s_rd_n_q, s_wr_n_q, s_rfsh_n_q;
    logic              s_rfsh_prev_q;
    logic [ADDR_W-1:0] s_addr_q;
    logic [7:0]        s_data_q;

    // Register every bus pin once; classification only ever looks at s_*.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_m1_n_q      <= 1'b1;
            s_mreq_n_q    <= 1'b1;
            s_iorq_n_q    <= 1'b1;
            s_rd_n_q      <= 1'b1;
            s_wr_n_q      <= 1'b1;
            s_rfsh_n_q    <= 1'b1;
            s_rfsh_prev_q <= 1'b1;
            s_addr_q      <= '0;
            s_data_q      <= '0;
        end else begin
            s_m1_n_q      <= m1_n;
            s_mreq_n_q    <= mreq_n;
            s_iorq_n_q    <= iorq_n;
            s_rd_n_q      <= rd_n;
            s_wr_n_q      <= wr_n;
            s_rfsh_n_q    <= rfsh_n;
            s_rfsh_prev_q <= s_rfsh_n_q;
            s_addr_q      <= addr[ADDR_W-1:0];
            s_data_q      <= data;
        end
    end

    logic  strobe;
    logic  rfsh_fall;
    seen_t cur;

    assign strobe    = !s_mreq_n_q || !s_iorq_n_q;
    assign rfsh_fall = s_rfsh_prev_q && !s_rfsh_n_q;
    assign cur       = '{m1:   !s_m1_n_q,
                         rd:   !s_rd_n_q,
                         wr:   !s_wr_n_q,
                         rfsh: !s_rfsh_n_q,
                         io:   !s_iorq_n_q,
                         mem:  !s_mreq_n_q};

    // ------------------------------------------------------------------
    // Free-running timestamp
    // ------------------------------------------------------------------
    logic [TS_W-1:0] ts_q;

    // Timestamp advances every clock and wraps; clear never touches it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ts_q <= '0;
        else        ts_q <= ts_q + 1'b1;
    end

    // ------------------------------------------------------------------
    // Window tracking FSM
    // ------------------------------------------------------------------
    logic [0:0]        state_q, state_d;
    seen_t             seen_q, seen_d;
    logic [ADDR_W-1:0] win_addr_q, win_addr_d;
    logic [7:0]        win_data_q, win_data_d;
    logic [TS_W-1:0]   ts_start_q, ts_start_d;
    logic              close;

    // Open on strobe, accumulate while strobing, close on strobe loss or
    // split on a falling RFSH (fetch flows straight into refresh).
    // NOTE: every combinational output gets a default first so no path
    // leaves a signal unassigned and infers a latch.
    always_comb begin
        state_d    = state_q;
        seen_d     = seen_q;
        win_addr_d = win_addr_q;
        win_data_d = win_data_q;
        ts_start_d = ts_start_q;
        close      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (strobe) begin
                    state_d    = ST_ACTIVE;
                    seen_d     = cur;
                    win_addr_d = s_addr_q;
                    win_data_d = s_data_q;
                    ts_start_d = ts_q;
                end
            end
            ST_ACTIVE: begin
                if (!strobe) begin
                    close   = 1'b1;
                    state_d = ST_IDLE;
                end else if (rfsh_fall) begin
                    close      = 1'b1;
                    seen_d     = cur;
                    win_addr_d = s_addr_q;
                    win_data_d = s_data_q;
                    ts_start_d = ts_q;
                end else begin
                    seen_d     = seen_t'(seen_q | cur);
                    win_addr_d = s_addr_q;
                    win_data_d = s_data_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Window state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            seen_q     <= '0;
            win_addr_q <= '0;
            win_data_q <= '0;
            ts_start_q <= '0;
        end else begin
            state_q    <= state_d;
            seen_q     <= seen_d;
            win_addr_q <= win_addr_d;
            win_data_q <= win_data_d;
            ts_start_q <= ts_start_d;
        end
    end

    // Priority-ordered decode of what a window contained.
    function automatic logic [2:0] classify(input seen_t s);
        if      (s.io   && s.m1)  return T_INT_ACK;
        else if (s.rfsh && s.mem) return T_REFRESH;
        else if (s.m1   && s.rd)  return T_FETCH;
        else if (s.mem  && s.wr)  return T_MEM_WR;
        else if (s.mem  && s.rd)  return T_MEM_RD;
        else if (s.io   && s.wr)  return T_IO_WR;
        else if (s.io   && s.rd)  return T_IO_RD;
        else                      return T_UNKNOWN;
    endfunction

    logic [2:0] close_type;
    logic [7:0] admit;

    assign close_type = classify(seen_q);
    // Unknown cycles have no mask bit; they are always admitted so bus
    // anomalies stay visible while capture is enabled.
    assign admit      = {1'b1, filter_mask};

    // ------------------------------------------------------------------
    // Record staging: formed on the close edge, enters the FIFO next edge
    // ------------------------------------------------------------------
    logic pend_valid_q;
    rec_t pend_rec_q;

    // Latch the closed window as a record if capture and filter allow it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_q <= 1'b0;
            pend_rec_q   <= '0;
        end else begin
            pend_valid_q <= close && enable && admit[close_type];
            if (close) begin
                pend_rec_q <= '{typ:  close_type,
                                addr: win_addr_q,
                                data: win_data_q,
                                ts:   ts_start_q};
            end
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead FIFO with drop accounting
    // ------------------------------------------------------------------
    rec_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] count_q;
    logic          overflow_q;
    logic [7:0]    drop_cnt_q;

    logic empty, full_c, pop_ok, push_ok, drop;
    rec_t head;

    assign empty   = (count_q == '0);
    assign full_c  = (count_q == LW'(DEPTH));
    assign pop_ok  = pop && !empty;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign push_ok = pend_valid_q && (!full_c || pop_ok);
    assign drop    = pend_valid_q && full_c && !pop_ok;

    // Pointers, occupancy and overflow bookkeeping; clear wins over all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (clear) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
            end
        end
    end

    // Record storage write port.
    // NOTE: the storage array has no reset; occupancy is tracked by the
    // pointers, and the outputs are gated to zero whenever it is empty.
    always_ff @(posedge clk) begin
        if (push_ok && !clear) mem_q[wr_ptr_q] <= pend_rec_q;
    end

    assign head      = mem_q[rd_ptr_q];
    assign rec_valid = !empty;
    assign rec_type  = empty ? '0 : head.typ;
    assign rec_addr  = empty ? '0 : head.addr;
    assign rec_data  = empty ? '0 : head.data;
    assign rec_ts    = empty ? '0 : head.ts;
    assign level     = count_q;
    assign full      = full_c;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_z80_bus_tracer.sv
// Directed self-checking bench for z80_bus_tracer (DEPTH=4).
// Bus pins are driven right after the falling edge and outputs are
// sampled on the falling edge, away from the capturing rising edge.

module tb_z80_bus_tracer;

    // Control vectors, order {m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n}.
    localparam logic [5:0] CTL_IDLE  = 6'b111111;
    localparam logic [5:0] CTL_FETCH = 6'b001011;
    localparam logic [5:0] CTL_RFSH  = 6'b101110;
    localparam logic [5:0] CTL_MRD   = 6'b101011;
    localparam logic [5:0] CTL_MWR   = 6'b101101;
    localparam logic [5:0] CTL_IOWR  = 6'b110101;
    localparam logic [5:0] CTL_INTA  = 6'b010111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m1_n = 1'b1, mreq_n = 1'b1, iorq_n = 1'b1;
    logic        rd_n = 1'b1, wr_n = 1'b1, rfsh_n = 1'b1;
    logic [15:0] addr = '0;
    logic [7:0]  data = '0;
    logic        enable = 1'b1;
    logic [6:0]  filter_mask = 7'h7F;
    logic        pop = 1'b0;
    logic        clear = 1'b0;
    logic        rec_valid;
    logic [2:0]  rec_type;
    logic [15:0] rec_addr;
    logic [7:0]  rec_data;
    logic [15:0] rec_ts;
    logic [2:0]  level;
    logic        full;
    logic        overflow;
    logic [7:0]  drop_cnt;

    int total = 0;
    int bad   = 0;

    z80_bus_tracer #(.ADDR_W(16), .DEPTH(4), .TS_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m1_n        (m1_n),
        .mreq_n      (mreq_n),
        .iorq_n      (iorq_n),
        .rd_n        (rd_n),
        .wr_n        (wr_n),
        .rfsh_n      (rfsh_n),
        .addr        (addr),
        .data        (data),
        .enable      (enable),
        .filter_mask (filter_mask),
        .pop         (pop),
        .clear       (clear),
        .rec_valid   (rec_valid),
        .rec_type    (rec_type),
        .rec_addr    (rec_addr),
        .rec_data    (rec_data),
        .rec_ts      (rec_ts),
        .level       (level),
        .full        (full),
        .overflow    (overflow),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [5:0] ctl, input logic [15:0] a, input logic [7:0] d);
        {m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n} = ctl;
        addr = a;
        data = d;
        @(negedge clk);
    endtask

    // n strobe cycles of one kind, then one idle cycle.
    task automatic op(input logic [5:0] ctl, input logic [15:0] a, input logic [7:0] d, input int n);
        repeat (n) drive(ctl, a, d);
        drive(CTL_IDLE, 16'h0000, 8'h00);
    endtask

    // Opcode fetch (2 cycles) flowing straight into refresh (2 cycles).
    task automatic fetch(input logic [15:0] a, input logic [7:0] d);
        drive(CTL_FETCH, a, d);
        drive(CTL_FETCH, a, d);
        drive(CTL_RFSH, 16'h0000, 8'h00);
        drive(CTL_RFSH, 16'h0000, 8'h00);
        drive(CTL_IDLE, 16'h0000, 8'h00);
    endtask

    task automatic pop1();
        pop = 1'b1;
        cyc(1);
        pop = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic [2:0] t, input logic [15:0] a, input logic [7:0] d);
        check({tag, "_valid"}, 32'(rec_valid), 32'h1);
        check({tag, "_type"},  32'(rec_type),  32'(t));
        check({tag, "_addr"},  32'(rec_addr),  32'(a));
        check({tag, "_data"},  32'(rec_data),  32'(d));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},  32'(rec_valid), 32'h0);
        check({tag, "_level"},  32'(level),     32'h0);
        check({tag, "_full"},   32'(full),      32'h0);
        check({tag, "_ovf"},    32'(overflow),  32'h0);
        check({tag, "_drops"},  32'(drop_cnt),  32'h0);
        check({tag, "_type"},   32'(rec_type),  32'h0);
        check({tag, "_addr"},   32'(rec_addr),  32'h0);
        check({tag, "_data"},   32'(rec_data),  32'h0);
        check({tag, "_ts"},     32'(rec_ts),    32'h0);
    endtask

    logic [15:0] ts0;
    logic [15:0] ts_gap;
    logic [7:0]  acc;

    initial begin
        // Reset state.
        cyc(2);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        cyc(2);

        // Fetch 0x3E at 0x0000 followed by refresh at 0x0000.
        fetch(16'h0000, 8'h3E);
        cyc(1);
        check("fetch_lat_lvl", 32'(level), 32'h1);
        cyc(1);
        check("fetch_lvl", 32'(level), 32'h2);
        check_head("fetch", 3'd0, 16'h0000, 8'h3E);
        ts0 = rec_ts;
        pop1();
        check_head("rfsh", 3'd6, 16'h0000, rec_data);
        ts_gap = rec_ts - ts0;
        check("rfsh_ts_gap", 32'(ts_gap), 32'h2);
        pop1();
        check("empty_valid", 32'(rec_valid), 32'h0);
        check("empty_lvl", 32'(level), 32'h0);

        // LD A,3Eh / SUB 21h / LD (AA20h),A with only memory writes admitted.
        filter_mask = 7'b0000100;
        acc = 8'h3E;
        fetch(16'h0000, 8'h3E);
        op(CTL_MRD, 16'h0001, acc, 2);
        fetch(16'h0002, 8'hD6);
        op(CTL_MRD, 16'h0003, 8'h21, 2);
        acc = acc - 8'h21;
        fetch(16'h0004, 8'h32);
        op(CTL_MRD, 16'h0005, 8'h20, 2);
        op(CTL_MRD, 16'h0006, 8'hAA, 2);
        op(CTL_MWR, 16'hAA20, acc, 2);
        cyc(2);
        check("prog_lvl", 32'(level), 32'h1);
        check_head("prog_wr", 3'd2, 16'hAA20, 8'h1D);
        pop1();
        filter_mask = 7'h7F;

        // Interrupt acknowledge and I/O write.
        op(CTL_INTA, 16'h1234, 8'hFF, 2);
        op(CTL_IOWR, 16'h0012, 8'h55, 2);
        cyc(2);
        check("io_lvl", 32'(level), 32'h2);
        check_head("inta", 3'd5, 16'h1234, 8'hFF);
        pop1();
        check_head("iowr", 3'd4, 16'h0012, 8'h55);
        pop1();

        // Capture disabled: window tracked, nothing queued.
        enable = 1'b0;
        op(CTL_MRD, 16'h0777, 8'h77, 2);
        cyc(3);
        check("dis_lvl", 32'(level), 32'h0);
        enable = 1'b1;

        // Five reads into a 4-deep FIFO.
        for (int i = 0; i < 5; i++) op(CTL_MRD, 16'h0100 + 16'(i), 8'h10 + 8'(i), 2);
        cyc(2);
        check("ovf_lvl", 32'(level), 32'h4);
        check("ovf_full", 32'(full), 32'h1);
        check("ovf_flag", 32'(overflow), 32'h1);
        check("ovf_drops", 32'(drop_cnt), 32'h1);
        check_head("ovf_head", 3'd1, 16'h0100, 8'h10);

        // Push while full with a pop on the same edge: no drop.
        op(CTL_MRD, 16'h0200, 8'h20, 2);
        cyc(1);
        pop1();
        cyc(2);
        check("pp_lvl", 32'(level), 32'h4);
        check("pp_drops", 32'(drop_cnt), 32'h1);
        check_head("pp_head", 3'd1, 16'h0101, 8'h11);

        // 300 further drops saturate the counter.
        for (int i = 0; i < 300; i++) op(CTL_MRD, 16'h5000, 8'h50, 1);
        cyc(3);
        check("sat_drops", 32'(drop_cnt), 32'hFF);
        check("sat_ovf", 32'(overflow), 32'h1);
        check("sat_lvl", 32'(level), 32'h4);

        // Reset asserted in the middle of an open window.
        drive(CTL_MRD, 16'h4000, 8'h44);
        drive(CTL_MRD, 16'h4000, 8'h44);
        rst_n = 1'b0;
        #2;
        check_reset_outputs("midrst");
        {m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n} = CTL_IDLE;
        cyc(1);
        rst_n = 1'b1;
        cyc(4);
        check("midrst_after_lvl", 32'(level), 32'h0);

        // Refill to overflow, then clear in the middle of a write window.
        for (int i = 0; i < 5; i++) op(CTL_MRD, 16'h6000 + 16'(i), 8'h60, 1);
        cyc(3);
        check("pre_clr_ovf", 32'(overflow), 32'h1);
        drive(CTL_MWR, 16'h2222, 8'h77);
        clear = 1'b1;
        drive(CTL_MWR, 16'h2222, 8'h77);
        clear = 1'b0;
        drive(CTL_IDLE, 16'h0000, 8'h00);
        cyc(2);
        check("clr_lvl", 32'(level), 32'h1);
        check("clr_ovf", 32'(overflow), 32'h0);
        check("clr_drops", 32'(drop_cnt), 32'h0);
        check_head("clr_head", 3'd2, 16'h2222, 8'h77);
        pop1();

        // Clear on the exact edge a record enters the FIFO discards it.
        op(CTL_MRD, 16'h3000, 8'h33, 2);
        cyc(1);
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        cyc(2);
        check("clr_push_lvl", 32'(level), 32'h0);
        check("clr_push_valid", 32'(rec_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
